// File: rtl/echo_pkg.sv
// Shared types and default constants for the ultrasonic echo distance meter.
package echo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ECHO,
    MEASURE,
    DONE,
    FAIL
  } state_t;

  localparam int TICKS_PER_CM_50MHZ = 2900;
  localparam int MAX_CM             = 400;
  localparam int NEAR_CM            = 20;
  localparam int WAIT_TICKS         = 1000000;
  localparam int CM_W               = 10;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous level, with single-cycle
// rise/fall strobes derived from the synchronised level.
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync_q;
  logic prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta   <= 1'b0;
      sync_q <= 1'b0;
      prev   <= 1'b0;
    end else begin
      meta   <= din;
      sync_q <= meta;
      prev   <= sync_q;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev;
  assign fall  = ~sync_q & prev;

endmodule

// File: rtl/echo_distance_meter.sv
// Times the ultrasonic echo pulse after each trigger rise and converts its
// width to centimetres with a prescaled counter (no divider).
module echo_distance_meter #(
  parameter int TICKS_PER_CM = echo_pkg::TICKS_PER_CM_50MHZ,
  parameter int MAX_CM       = echo_pkg::MAX_CM,
  parameter int WAIT_TICKS   = echo_pkg::WAIT_TICKS,
  parameter int NEAR_CM      = echo_pkg::NEAR_CM
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trig,
  input  logic       echo,
  output logic [9:0] distance_cm,
  output logic       dist_valid,
  output logic       timeout,
  output logic       obstacle,
  output logic       busy
);

  import echo_pkg::*;

  localparam int PRE_W  = (TICKS_PER_CM > 1) ? $clog2(TICKS_PER_CM) : 1;
  localparam int WAIT_W = (WAIT_TICKS > 1) ? $clog2(WAIT_TICKS) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICKS_PER_CM - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_TICKS - 1);
  localparam logic [9:0]        CM_LIMIT  = 10'(MAX_CM);
  localparam logic [9:0]        NEAR_LIM  = 10'(NEAR_CM);

  state_t            state;
  logic [PRE_W-1:0]  prescaler;
  logic [WAIT_W-1:0] wait_cnt;
  logic [9:0]        cm_cnt;

  logic trig_level, trig_rise, trig_fall;
  logic echo_level, echo_rise, echo_fall;
  logic unused_trig;

  sync_edge_detect u_trig_sync (
    .clk   (clk),
    .reset (reset),
    .din   (trig),
    .level (trig_level),
    .rise  (trig_rise),
    .fall  (trig_fall)
  );

  sync_edge_detect u_echo_sync (
    .clk   (clk),
    .reset (reset),
    .din   (echo),
    .level (echo_level),
    .rise  (echo_rise),
    .fall  (echo_fall)
  );

  assign unused_trig = trig_level ^ trig_fall;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      prescaler   <= '0;
      wait_cnt    <= '0;
      cm_cnt      <= '0;
      distance_cm <= '0;
      dist_valid  <= 1'b0;
      timeout     <= 1'b0;
      obstacle    <= 1'b0;
    end else begin
      dist_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (trig_rise) begin
            state    <= WAIT_ECHO;
            wait_cnt <= '0;
          end
        end
        WAIT_ECHO: begin
          wait_cnt <= wait_cnt + 1'b1;
          // The rise cycle already sees echo high, so it is the first tick.
          if (echo_rise) begin
            state     <= MEASURE;
            prescaler <= PRE_W'(1);
            cm_cnt    <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            state <= FAIL;
          end
        end
        MEASURE: begin
          if (echo_fall) begin
            state <= DONE;
          end else if (echo_level) begin
            if (prescaler == PRE_LAST) begin
              prescaler <= '0;
              if (cm_cnt == CM_LIMIT) begin
                state <= FAIL;
              end else begin
                cm_cnt <= cm_cnt + 10'd1;
              end
            end else begin
              prescaler <= prescaler + 1'b1;
            end
          end
        end
        DONE: begin
          distance_cm <= cm_cnt;
          dist_valid  <= 1'b1;
          timeout     <= 1'b0;
          obstacle    <= (cm_cnt < NEAR_LIM);
          state       <= IDLE;
        end
        FAIL: begin
          timeout  <= 1'b1;
          obstacle <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_echo_distance_meter.sv
// Directed, self-checking bench for echo_distance_meter with small
// parameters (10 ticks/cm, 40 cm max, 100-cycle echo wait, 5 cm threshold).
module tb_echo_distance_meter;

  localparam int TICKS = 10;
  localparam int MAXC  = 40;
  localparam int WAITT = 100;
  localparam int NEAR  = 5;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       trig  = 1'b0;
  logic       echo  = 1'b0;
  logic [9:0] distance_cm;
  logic       dist_valid;
  logic       timeout;
  logic       obstacle;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (dist_valid === 1'b1) pulses++;

  echo_distance_meter #(
    .TICKS_PER_CM (TICKS),
    .MAX_CM       (MAXC),
    .WAIT_TICKS   (WAITT),
    .NEAR_CM      (NEAR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .trig        (trig),
    .echo        (echo),
    .distance_cm (distance_cm),
    .dist_valid  (dist_valid),
    .timeout     (timeout),
    .obstacle    (obstacle),
    .busy        (busy)
  );

  // Every stimulus helper leaves the bench 2 time units after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic arm();
    trig = 1'b1;
    tick(5);
    trig = 1'b0;
    tick(1);
  endtask

  task automatic echo_pulse(input int n);
    echo = 1'b1;
    tick(n);
    echo = 1'b0;
  endtask

  task automatic measure(input int width);
    pulses = 0;
    arm();
    tick(5);
    echo_pulse(width);
    tick(8);
  endtask

  task automatic test_reset();
    checks++; if (distance_cm !== 10'd0 || dist_valid !== 1'b0 || timeout !== 1'b0 || obstacle !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL por_state got d=%0d v=%0d t=%0d o=%0d b=%0d exp all 0", distance_cm, dist_valid, timeout, obstacle, busy); end
    measure(25);
    checks++; if (distance_cm !== 10'd2) begin failures++; $display("[TB] FAIL pre_reset_dist got=%0d exp=2", distance_cm); end
    pulses = 0;
    arm();
    tick(5);
    echo = 1'b1;
    tick(7);
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL busy_measuring got=%0d exp=1", busy); end
    #1 reset = 1'b1;
    #1;
    checks++; if (distance_cm !== 10'd0 || dist_valid !== 1'b0 || timeout !== 1'b0 || obstacle !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL async_reset got d=%0d v=%0d t=%0d o=%0d b=%0d exp all 0", distance_cm, dist_valid, timeout, obstacle, busy); end
    echo = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(3);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL busy_after_release got=%0d exp=0", busy); end
  endtask

  task automatic test_measure();
    logic early;
    pulses = 0;
    arm();
    tick(10);
    echo_pulse(125);
    early = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (dist_valid !== 1'b0) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin failures++; $display("[TB] FAIL valid_latency_early got=1 exp=0"); end
    @(posedge clk);
    #1;
    checks++; if (dist_valid !== 1'b1) begin failures++; $display("[TB] FAIL valid_latency_4th got=%0d exp=1", dist_valid); end
    checks++; if (distance_cm !== 10'd12) begin failures++; $display("[TB] FAIL dist_125 got=%0d exp=12", distance_cm); end
    checks++; if (timeout !== 1'b0 || obstacle !== 1'b0) begin failures++; $display("[TB] FAIL flags_125 got t=%0d o=%0d exp t=0 o=0", timeout, obstacle); end
    tick(6);
    checks++; if (pulses !== 1) begin failures++; $display("[TB] FAIL pulses_125 got=%0d exp=1", pulses); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL busy_after_done got=%0d exp=0", busy); end
  endtask

  task automatic test_near();
    measure(30);
    checks++; if (distance_cm !== 10'd3) begin failures++; $display("[TB] FAIL dist_30 got=%0d exp=3", distance_cm); end
    checks++; if (obstacle !== 1'b1 || timeout !== 1'b0) begin failures++; $display("[TB] FAIL flags_30 got o=%0d t=%0d exp o=1 t=0", obstacle, timeout); end
    checks++; if (pulses !== 1) begin failures++; $display("[TB] FAIL pulses_30 got=%0d exp=1", pulses); end
    measure(9);
    checks++; if (distance_cm !== 10'd0) begin failures++; $display("[TB] FAIL dist_9 got=%0d exp=0", distance_cm); end
    checks++; if (obstacle !== 1'b1) begin failures++; $display("[TB] FAIL obstacle_9 got=%0d exp=1", obstacle); end
    checks++; if (pulses !== 1) begin failures++; $display("[TB] FAIL pulses_9 got=%0d exp=1", pulses); end
  endtask

  task automatic test_timeout();
    pulses = 0;
    arm();
    tick(94);
    checks++; if (timeout !== 1'b0 || busy !== 1'b1) begin failures++; $display("[TB] FAIL wait_not_expired got t=%0d b=%0d exp t=0 b=1", timeout, busy); end
    tick(6);
    checks++; if (timeout !== 1'b1) begin failures++; $display("[TB] FAIL no_echo_timeout got=%0d exp=1", timeout); end
    checks++; if (busy !== 1'b0 || obstacle !== 1'b0) begin failures++; $display("[TB] FAIL no_echo_flags got b=%0d o=%0d exp b=0 o=0", busy, obstacle); end
    checks++; if (distance_cm !== 10'd0 || pulses !== 0) begin failures++; $display("[TB] FAIL no_echo_held got d=%0d p=%0d exp d=0 p=0", distance_cm, pulses); end
  endtask

  task automatic test_range();
    measure(500);
    checks++; if (timeout !== 1'b1) begin failures++; $display("[TB] FAIL over_range_timeout got=%0d exp=1", timeout); end
    checks++; if (pulses !== 0 || distance_cm !== 10'd0) begin failures++; $display("[TB] FAIL over_range_held got p=%0d d=%0d exp p=0 d=0", pulses, distance_cm); end
    measure(60);
    checks++; if (distance_cm !== 10'd6) begin failures++; $display("[TB] FAIL dist_60 got=%0d exp=6", distance_cm); end
    checks++; if (timeout !== 1'b0 || obstacle !== 1'b0 || pulses !== 1) begin failures++; $display("[TB] FAIL flags_60 got t=%0d o=%0d p=%0d exp t=0 o=0 p=1", timeout, obstacle, pulses); end
  endtask

  task automatic test_back_to_back();
    pulses = 0;
    arm();
    tick(5);
    echo = 1'b1;
    tick(20);
    trig = 1'b1;
    tick(3);
    // Sub-cycle low glitch that falls between two sampling edges.
    #1 echo = 1'b0;
    #2 echo = 1'b1;
    tick(2);
    trig = 1'b0;
    tick(25);
    echo = 1'b0;
    tick(8);
    checks++; if (distance_cm !== 10'd5 || pulses !== 1) begin failures++; $display("[TB] FAIL retrig_glitch got d=%0d p=%0d exp d=5 p=1", distance_cm, pulses); end
    checks++; if (busy !== 1'b0 || timeout !== 1'b0 || obstacle !== 1'b0) begin failures++; $display("[TB] FAIL retrig_flags got b=%0d t=%0d o=%0d exp 0 0 0", busy, timeout, obstacle); end
    pulses = 0;
    arm();
    tick(5);
    echo = 1'b1;
    tick(15);
    #4 reset = 1'b1;
    #1;
    checks++; if (distance_cm !== 10'd0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_mid_measure got d=%0d b=%0d exp d=0 b=0", distance_cm, busy); end
    tick(3);
    reset = 1'b0;
    tick(10);
    echo = 1'b0;
    tick(8);
    checks++; if (pulses !== 0 || distance_cm !== 10'd0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL after_reset_idle got p=%0d d=%0d b=%0d exp 0 0 0", pulses, distance_cm, busy); end
  endtask

  initial begin
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(2);
    test_reset();
    test_measure();
    test_near();
    test_timeout();
    test_range();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=expired exp=finished");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/echo_distance_meter.md
Name: echo_distance_meter

Overview:
Downstream partner of the ultrasonic trigger generator on the car's obstacle-sensing path. Each rising edge of the trigger level arms one measurement. The block then times the sensor's echo pulse and converts the width to centimetres with a prescaled counter, so no divider is needed. It publishes a held distance, a one-cycle valid strobe, a range/timeout flag and an obstacle flag for the motion controller.

Parameters:
TICKS_PER_CM, 2900, clk cycles per cm of echo width (58 us at 50 MHz)
MAX_CM, 400, largest valid distance; must be ≤1023
WAIT_TICKS, 1000000, max cycles from trig rise to echo rise (20 ms)
NEAR_CM, 20, obstacle threshold in cm

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
trig  in  1  trigger level from trigger generator; rising edge arms a measurement
echo  in  1  raw sensor echo, asynchronous to clk
distance_cm  out  10  last valid distance, held between measurements
dist_valid  out  1  one-cycle strobe when distance_cm updates
timeout  out  1  1 = last measurement failed (no echo, or out of range)
obstacle  out  1  distance_cm < NEAR_CM and timeout == 0
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, active-high): state=IDLE; all counters 0; distance_cm=0, dist_valid=0, timeout=0, obstacle=0, busy=0.
- Input conditioning:
  - trig and echo each pass through a 2-FF synchroniser plus one edge register.
  - This yields single-cycle rise/fall strobes from the synchronised signals trig_s and echo_s.
- FSM states: IDLE, WAIT_ECHO, MEASURE, DONE, FAIL.
- IDLE:
  - trig rise -> WAIT_ECHO; wait counter cleared.
  - echo edges are ignored in IDLE.
- WAIT_ECHO:
  - Wait counter increments every cycle.
  - echo rise -> MEASURE; prescaler and cm_cnt cleared.
  - Otherwise, when wait counter == WAIT_TICKS-1 -> FAIL.
  - If echo rise and the limit occur in the same cycle, echo rise wins.
- MEASURE:
  - Prescaler counts 0..TICKS_PER_CM-1 in every cycle where echo_s=1. On wrap, cm_cnt increments.
  - Result: N echo-high cycles give cm_cnt = floor(N/TICKS_PER_CM).
  - echo fall -> DONE. The fall cycle is not counted.
  - If a wrap would take cm_cnt to MAX_CM+1 -> FAIL. A wrap in the same cycle as echo fall cannot occur because the fall cycle is not counted.
- DONE (one cycle): distance_cm<=cm_cnt, dist_valid=1, timeout<=0 -> IDLE.
- FAIL (one cycle): timeout<=1, dist_valid stays 0, distance_cm held -> IDLE.
- After FAIL with echo still high, nothing is measured until the next trig rise, which needs a fresh echo rise.
- trig rise while busy: ignored, no restart.
- obstacle is registered, updated in the same cycle as distance_cm/timeout: obstacle = (distance_cm < NEAR_CM) & ~timeout.
- Latency: dist_valid asserts on the 4th rising clk edge after the first edge that samples echo=0 at the pin (2 sync stages + edge detect + DONE).
- Width rules:
  - Prescaler width is $clog2(TICKS_PER_CM).
  - Wait counter width is $clog2(WAIT_TICKS).
  - cm_cnt is 10 bits. Its saturation check compares against MAX_CM before incrementing, so there is no wrap-around.
- Reset mid-operation: immediate return to IDLE with reset values. The held distance is lost (returns to 0).

Decomposition:
- Shared package (echo_pkg): FSM state enum and default constants (TICKS_PER_CM_50MHZ=2900, MAX_CM=400, NEAR_CM=20, WAIT_TICKS=1000000).
- One sub-module: sync_edge_detect (2-FF synchroniser + rise/fall strobes, async active-high reset to 0), instantiated for trig and for echo.

Test Plan:
(Bench parameters: TICKS_PER_CM=10, MAX_CM=40, WAIT_TICKS=100, NEAR_CM=5.)
1. Assert reset mid-run at an arbitrary phase -> all outputs 0 immediately, without waiting for a clk edge; after release, busy=0.
2. trig rise, echo high for 125 cycles starting 10 cycles later -> exactly one dist_valid pulse, distance_cm=12, timeout=0, obstacle=0; pulse lands on the 4th edge after echo fall.
3. Echo high 30 cycles -> distance_cm=3, obstacle=1; then echo high 9 cycles -> distance_cm=0, obstacle=1.
4. trig rise, no echo -> timeout=1 about 100 cycles after armed, no dist_valid, distance_cm held at previous 0/3, obstacle=0.
5. Echo high 500 cycles -> FAIL when cm_cnt would hit 41, timeout=1, no dist_valid; a following 60-cycle echo gives distance_cm=6, timeout=0.
6. Second trig rise and echo glitches while in MEASURE -> ignored, result unchanged; reset asserted mid-MEASURE -> IDLE, distance_cm=0, no dist_valid.
